// File: rtl/ram_latency_model_if.sv
// Memory-controller to RAM handshake bundle.
// Controller drives the request; the RAM returns ramload/ramstate.
interface ram_latency_model_if;
   logic [31:0] memaddr;
   logic [31:0] memstore;
   logic        memREN;
   logic        memWEN;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   modport master (
      output memaddr, memstore, memREN, memWEN,
      input  ramload, ramstate
   );

   modport slave (
      input  memaddr, memstore, memREN, memWEN,
      output ramload, ramstate
   );
endinterface

// File: rtl/ram_latency_model.sv
// RAM-side stage with a fixed BUSY latency per access.
// A held request completes after LAT busy cycles with one ACCESS cycle.
module ram_latency_model #(
   parameter int LAT    = 2,
   parameter int AWORDS = 10
) (
   input logic CLK,
   input logic nRST,
   ram_latency_model_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam int         DEPTH = 1 << AWORDS;
   localparam logic [3:0] LATC  = 4'(LAT);

   logic [31:0] mem [DEPTH];

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [31:0] caddr, cdata;
   logic        cwen;
   logic        cap, fin;
   logic [31:0] rdata;

   logic              anyreq, bad, good, same;
   logic [AWORDS-1:0] idx;

   assign anyreq = bus.memREN | bus.memWEN;
   assign bad    = anyreq & ((bus.memREN & bus.memWEN)
                  | (|bus.memaddr[1:0])
                  | (|bus.memaddr[31:AWORDS+2]));
   assign good   = anyreq & ~bad;
   assign same   = (bus.memWEN == cwen)
                 & (bus.memaddr == caddr)
                 & (bus.memstore == cdata);
   assign idx    = bus.memaddr[AWORDS+1:2];

   assign bus.ramstate = state;
   assign bus.ramload  = rdata;

   // Next state: sample in IDLE/DONE/ERR, count down or track changes in WAIT.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cap     = 1'b0;
      fin     = 1'b0;
      unique case (state)
         WAIT: begin
            if (!anyreq) begin
               state_n = IDLE;
            end else if (bad) begin
               state_n = ERR;
            end else if (!same) begin
               cap = 1'b1;
               cnt_n = LATC;
               if (LAT == 0) begin
                  state_n = DONE;
                  fin = 1'b1;
               end else begin
                  state_n = WAIT;
               end
            end else if (cnt > 4'd1) begin
               cnt_n = cnt - 4'd1;
            end else begin
               state_n = DONE;
               fin = 1'b1;
            end
         end
         default: begin
            if (good) begin
               cap = 1'b1;
               cnt_n = LATC;
               if (LAT == 0) begin
                  state_n = DONE;
                  fin = 1'b1;
               end else begin
                  state_n = WAIT;
               end
            end else if (bad) begin
               state_n = ERR;
            end else begin
               state_n = IDLE;
            end
         end
      endcase
   end

   // State, counter, captured request and registered read data.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         cnt   <= 4'd0;
         caddr <= 32'd0;
         cdata <= 32'd0;
         cwen  <= 1'b0;
         rdata <= 32'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (cap) begin
            caddr <= bus.memaddr;
            cdata <= bus.memstore;
            cwen  <= bus.memWEN;
         end
         rdata <= (fin && !bus.memWEN) ? mem[idx] : 32'd0;
      end
   end

   // Backing store: written only on the edge that completes a write.
   always_ff @(posedge CLK) begin
      if (nRST && fin && bus.memWEN) begin
         mem[idx] <= bus.memstore;
      end
   end

endmodule

// File: tb/tb_ram_latency_model.sv
// Bench for ram_latency_model: LAT=0/2/3 instances on shared stimulus,
// checked against a run-length transaction model.
module tb_ram_latency_model;

   localparam int AW = 10;

   logic        clk = 1'b0;
   logic        nrst;
   logic        ren, wen;
   logic [31:0] addr, data;

   int nchk = 0;
   int nerr = 0;

   ram_latency_model_if b0 ();
   ram_latency_model_if b2 ();
   ram_latency_model_if b3 ();

   assign b0.memaddr  = addr;
   assign b0.memstore = data;
   assign b0.memREN   = ren;
   assign b0.memWEN   = wen;
   assign b2.memaddr  = addr;
   assign b2.memstore = data;
   assign b2.memREN   = ren;
   assign b2.memWEN   = wen;
   assign b3.memaddr  = addr;
   assign b3.memstore = data;
   assign b3.memREN   = ren;
   assign b3.memWEN   = wen;

   ram_latency_model #(.LAT(0), .AWORDS(AW)) d0 (.CLK(clk), .nRST(nrst), .bus(b0));
   ram_latency_model #(.LAT(2), .AWORDS(AW)) d2 (.CLK(clk), .nRST(nrst), .bus(b2));
   ram_latency_model #(.LAT(3), .AWORDS(AW)) d3 (.CLK(clk), .nRST(nrst), .bus(b3));

   always #5 clk = ~clk;

   logic [1:0]  st [3];
   logic [31:0] ld [3];
   assign st[0] = b0.ramstate;
   assign st[1] = b2.ramstate;
   assign st[2] = b3.ramstate;
   assign ld[0] = b0.ramload;
   assign ld[1] = b2.ramload;
   assign ld[2] = b3.ramload;

   int          lats [3] = '{0, 2, 3};
   int          run  [3];
   logic [31:0] mm   [3][32];
   logic [1:0]  es   [3];
   logic [31:0] el   [3];
   logic        pren, pwen;
   logic [31:0] paddr, pdata;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   // Reference: a held identical request repeats transactions of LAT+1
   // edges; the last edge of each is ACCESS, the rest BUSY.
   task automatic model();
      bit anyr, illg, same;
      int p;
      anyr = ren | wen;
      illg = anyr && ((ren && wen) || addr[1:0] != 2'd0
                      || addr >= 32'(4 * (1 << AW)));
      same = (ren == pren) && (wen == pwen)
          && (addr == paddr) && (data == pdata);
      for (int d = 0; d < 3; d++) begin
         el[d] = 32'd0;
         if (!nrst || !anyr) begin
            run[d] = 0;
            es[d] = 2'd0;
         end else if (illg) begin
            run[d] = 0;
            es[d] = 2'd3;
         end else begin
            run[d] = same ? run[d] + 1 : 1;
            p = (run[d] - 1) % (lats[d] + 1);
            if (p == lats[d]) begin
               es[d] = 2'd2;
               if (wen) mm[d][addr[6:2]] = data;
               else el[d] = mm[d][addr[6:2]];
            end else begin
               es[d] = 2'd1;
            end
         end
      end
      pren = ren;
      pwen = wen;
      paddr = addr;
      pdata = data;
   endtask

   task automatic step();
      @(posedge clk);
      model();
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("state_lat%0d", lats[d]), 32'(st[d]), 32'(es[d]));
         chk($sformatf("load_lat%0d", lats[d]), ld[d], el[d]);
      end
   endtask

   task automatic hold(input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] dv,
                       input int n);
      ren = r;
      wen = w;
      addr = a;
      data = dv;
      repeat (n) step();
   endtask

   task automatic pulse();
      nrst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("rst_async_state", 32'(st[d]), 32'd0);
         chk("rst_async_load", ld[d], 32'd0);
      end
      ren = 1'b0;
      wen = 1'b0;
      addr = 32'd0;
      step();
      nrst = 1'b1;
   endtask

   initial begin
      int k;
      logic [31:0] a;
      nrst = 1'b0;
      ren = 1'b0;
      wen = 1'b0;
      addr = 32'd0;
      data = 32'd0;
      pren = 1'b0;
      pwen = 1'b0;
      paddr = 32'd0;
      pdata = 32'd0;
      for (int d = 0; d < 3; d++) begin
         run[d] = 0;
         for (int w = 0; w < 32; w++) mm[d][w] = 'x;
      end
      #2;
      for (int d = 0; d < 3; d++) begin
         chk("reset_state", 32'(st[d]), 32'd0);
         chk("reset_load", ld[d], 32'd0);
      end
      step();
      step();
      nrst = 1'b1;

      for (int w = 0; w < 32; w++) begin
         hold(1'b0, 1'b1, 32'(w * 4), 32'hA5A50000 | 32'(w), 4);
         hold(1'b0, 1'b0, 32'd0, 32'd0, 1);
      end

      hold(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3);
      hold(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3);
      chk("wr_rd_state", 32'(st[1]), 32'd2);
      chk("wr_rd_load", ld[1], 32'hDEADBEEF);

      hold(1'b1, 1'b0, 32'h10, 32'd0, 3);
      chk("lat0_hold_load", ld[0], 32'hDEADBEEF);

      hold(1'b0, 1'b1, 32'h20, 32'h12345678, 2);
      hold(1'b0, 1'b0, 32'd0, 32'd0, 1);
      chk("drop_state", 32'(st[2]), 32'd0);
      hold(1'b1, 1'b0, 32'h20, 32'd0, 4);
      chk("drop_keep", ld[2], 32'hA5A50008);

      hold(1'b1, 1'b0, 32'h30, 32'd0, 1);
      hold(1'b1, 1'b0, 32'h34, 32'd0, 3);
      chk("retarget_load", ld[1], 32'hA5A5000D);

      hold(1'b1, 1'b1, 32'h10, 32'd0, 2);
      chk("both_en", 32'(st[1]), 32'd3);
      hold(1'b1, 1'b0, 32'h2, 32'd0, 2);
      chk("misalign_rd", 32'(st[2]), 32'd3);
      hold(1'b0, 1'b1, 32'h2, 32'h55, 2);
      chk("misalign_wr", 32'(st[0]), 32'd3);
      hold(1'b1, 1'b0, 32'h0, 32'd0, 4);

      hold(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 2);
      pulse();
      hold(1'b1, 1'b0, 32'h40, 32'd0, 4);
      chk("rst_nowrite", ld[2], 32'hA5A50010);
      hold(1'b0, 1'b0, 32'd0, 32'd0, 1);

      for (int i = 0; i < 250; i++) begin
         k = $urandom_range(0, 9);
         a = 32'($urandom_range(0, 31)) << 2;
         unique case (1'b1)
            (k <= 5): hold(1'($urandom_range(0, 1)) ? 1'b1 : 1'b0,
                           1'b0, a, $urandom, 0);
            default: ;
         endcase
         if (k <= 5) begin
            if ($urandom_range(0, 1) == 1) ren = 1'b1;
            else ren = 1'b0;
            wen = ~ren;
            addr = a;
            data = $urandom;
         end else if (k == 6) begin
            ren = 1'b0;
            wen = 1'b0;
            addr = 32'd0;
         end else if (k == 7) begin
            ren = 1'b1;
            wen = 1'b1;
            addr = a;
         end else if (k == 8) begin
            ren = 1'($urandom_range(0, 1));
            wen = ~ren;
            addr = a | 32'($urandom_range(1, 3));
         end else begin
            ren = 1'($urandom_range(0, 1));
            wen = ~ren;
            addr = ($urandom_range(0, 1) == 1) ? 32'h8000_0000
                 : 32'h1000 + a;
         end
         repeat ($urandom_range(1, 6)) step();
         if ($urandom_range(0, 29) == 0) pulse();
      end

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
